// File: rtl/systolic_mv_stream.sv
// Streaming matrix-vector multiplier: stored ROWS x COLS signed weights, LANES MACs per cycle,
// requantised (shift + saturate) valid/ready output. Optional MV_ROUND_EN: round half away from zero.
module systolic_mv_stream #(
   parameter int DATA_W = 8,
   parameter int ROWS   = 64,
   parameter int COLS   = 64,
   parameter int LANES  = 8,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 0,
   localparam int NBLK  = COLS / LANES,
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int BW    = (NBLK > 1) ? $clog2(NBLK) : 1,
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    w_en,
   input  logic [RW-1:0]           w_row,
   input  logic [BW-1:0]           w_blk,
   input  logic [LANES*DATA_W-1:0] w_data,
   input  logic                    vin_valid,
   output logic                    vin_ready,
   input  logic [DATA_W-1:0]       vin_data,
   input  logic                    vin_last,
   output logic                    vout_valid,
   input  logic                    vout_ready,
   output logic [OUT_W-1:0]        vout_data,
   output logic                    vout_sat,
   output logic                    vout_last,
   output logic                    busy,
   output logic                    err
);
   localparam int PW = 2 * DATA_W;
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] MINV = -MAXV - 1;
`ifdef MV_ROUND_EN
   localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [ACC_W:0] RND_P = (SHIFT > 0) ? (ACC_W+1)'(1 << SH1) : '0;
   localparam logic signed [ACC_W:0] RND_N = (SHIFT > 0) ? (ACC_W+1)'((1 << SH1) - 1) : '0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t                         r_state;
   logic                           r_vin_ready, r_err;
   logic [BW-1:0]                  r_lblk, r_blk;
   logic [LW-1:0]                  r_lane;
   logic [RW-1:0]                  r_row;
   logic signed [ACC_W-1:0]        r_acc, r_res;
   logic                           r_res_vld, r_res_last;
   logic                           r_vout_valid, r_vout_sat, r_vout_last;
   logic [OUT_W-1:0]               r_vout_data;
   logic [LANES-1:0][DATA_W-1:0]   r_wmem [ROWS][NBLK];
   logic [LANES-1:0][DATA_W-1:0]   r_vec [NBLK];

   logic                           w_vacc, w_vend, w_blk_end, w_wr_ok, w_res_mv, w_stall;
   logic signed [PW-1:0]           w_prod;
   logic signed [ACC_W-1:0]        w_psum, w_base, w_acc_nxt;
   logic signed [ACC_W:0]          w_t;
   logic [OUT_W-1:0]               w_qd;
   logic                           w_sat;

   assign w_vacc    = vin_valid & r_vin_ready;
   assign w_vend    = (r_lblk == BW'(NBLK-1)) && (r_lane == LW'(LANES-1));
   assign w_blk_end = (r_blk == BW'(NBLK-1));
   assign w_wr_ok   = (r_state == S_IDLE) || (r_state == S_LOAD);
   // Holding stage r_res frees when the output register is empty or being popped this cycle.
   assign w_res_mv  = r_res_vld && (!r_vout_valid || vout_ready);
   assign w_stall   = w_blk_end && r_res_vld && !w_res_mv;

   always_comb begin
      w_prod = '0;
      w_psum = '0;
      for (int k = 0; k < LANES; k++) begin
         w_prod = PW'($signed(r_wmem[r_row][r_blk][k])) * PW'($signed(r_vec[r_blk][k]));
         w_psum = w_psum + ACC_W'(w_prod);
      end
      w_base    = (r_blk == '0) ? '0 : r_acc;
      w_acc_nxt = w_base + w_psum;
   end

   always_comb begin
      w_t = {r_res[ACC_W-1], r_res};
`ifdef MV_ROUND_EN
      w_t = w_t + (r_res[ACC_W-1] ? RND_N : RND_P);
`endif
      w_t   = w_t >>> SHIFT;
      w_sat = 1'b0;
      w_qd  = w_t[OUT_W-1:0];
      if (w_t > MAXV) begin
         w_sat = 1'b1;
         w_qd  = OUT_W'(MAXV);
      end else if (w_t < MINV) begin
         w_sat = 1'b1;
         w_qd  = OUT_W'(MINV);
      end
   end

   // Storage arrays carry no reset.
   always_ff @(posedge clk) begin
      if (w_en && w_wr_ok) r_wmem[w_row][w_blk] <= w_data;
      if (w_vacc) r_vec[r_lblk][r_lane] <= vin_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_vin_ready  <= 1'b0;
         r_err        <= 1'b0;
         r_lblk       <= '0;
         r_lane       <= '0;
         r_blk        <= '0;
         r_row        <= '0;
         r_acc        <= '0;
         r_res        <= '0;
         r_res_vld    <= 1'b0;
         r_res_last   <= 1'b0;
         r_vout_valid <= 1'b0;
         r_vout_data  <= '0;
         r_vout_sat   <= 1'b0;
         r_vout_last  <= 1'b0;
      end else begin
         if (w_en && !w_wr_ok) r_err <= 1'b1;
         if (w_vacc && (vin_last != w_vend)) r_err <= 1'b1;
         if (w_res_mv) begin
            r_vout_valid <= 1'b1;
            r_vout_data  <= w_qd;
            r_vout_sat   <= w_sat;
            r_vout_last  <= r_res_last;
            r_res_vld    <= 1'b0;
         end else if (vout_ready) begin
            r_vout_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE, S_LOAD: begin
               r_vin_ready <= 1'b1;
               if (w_vacc) begin
                  if (w_vend) begin
                     r_state     <= S_COMPUTE;
                     r_vin_ready <= 1'b0;
                     r_lblk      <= '0;
                     r_lane      <= '0;
                     r_row       <= '0;
                     r_blk       <= '0;
                  end else begin
                     r_state <= S_LOAD;
                     if (r_lane == LW'(LANES-1)) begin
                        r_lane <= '0;
                        r_lblk <= r_lblk + BW'(1);
                     end else begin
                        r_lane <= r_lane + LW'(1);
                     end
                  end
               end
            end
            S_COMPUTE: if (!w_stall) begin
               if (w_blk_end) begin
                  r_res      <= w_acc_nxt;
                  r_res_vld  <= 1'b1;
                  r_res_last <= (r_row == RW'(ROWS-1));
                  r_blk      <= '0;
                  if (r_row == RW'(ROWS-1)) r_state <= S_DRAIN;
                  else r_row <= r_row + RW'(1);
               end else begin
                  r_acc <= w_acc_nxt;
                  r_blk <= r_blk + BW'(1);
               end
            end
            S_DRAIN: if (r_vout_valid && vout_ready && r_vout_last) begin
               r_state     <= S_IDLE;
               r_vin_ready <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign vin_ready  = r_vin_ready;
   assign vout_valid = r_vout_valid;
   assign vout_data  = r_vout_data;
   assign vout_sat   = r_vout_sat;
   assign vout_last  = r_vout_last;
   assign busy       = (r_state != S_IDLE);
   assign err        = r_err;
endmodule
